// File: rtl/mult_div_pkg.sv
// Shared types and constants for the signed multiply/divide unit.
package mult_div_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Magnitude of a two's complement word; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the pipeline controller and the mult/div unit.
interface mult_div_unit_if;
    import mult_div_pkg::*;

    logic              start;
    logic              MDCtrl;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              HILOWrite;
    logic [DATA_W-1:0] Hi;
    logic [DATA_W-1:0] Lo;
    logic              busy;
    logic              done;
    logic              div0;

    modport master (
        output start, MDCtrl, A, B, HILOWrite,
        input  Hi, Lo, busy, done, div0
    );

    modport slave (
        input  start, MDCtrl, A, B, HILOWrite,
        output Hi, Lo, busy, done, div0
    );

endinterface

// File: rtl/md_iter_step.sv
// One iteration of shift-add multiply or restoring divide on a 64-bit work word.
// MULT: work = {partial_hi, multiplier}; DIV: work = {remainder, dividend/quotient}.
module md_iter_step
    import mult_div_pkg::*;
(
    input  logic                  mode,
    input  logic [2*DATA_W-1:0]   work,
    input  logic [DATA_W-1:0]     operand,
    output logic [2*DATA_W-1:0]   result
);

    logic [DATA_W:0] add_sum;
    logic [DATA_W:0] trial;

    always_comb begin
        add_sum = {1'b0, work[2*DATA_W-1:DATA_W]}
                + (work[0] ? {1'b0, operand} : {(DATA_W+1){1'b0}});
        // Shifted remainder is 33 bits; bit 32 of the difference is the borrow.
        trial   = work[2*DATA_W-1:DATA_W-1] - {1'b0, operand};
        if (mode == MD_MULT) begin
            result = {add_sum, work[DATA_W-1:1]};
        end else if (!trial[DATA_W]) begin
            result = {trial[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
        end else begin
            result = {work[2*DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Signed MULT/DIV unit with HI/LO registers, 34-cycle iterative datapath.
// Define MULT_DIV_FAST_MULT_EN for a single-cycle multiply (3-cycle MULT).
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave bus
);

    md_state_t             state_reg, state_next;
    logic [5:0]            cnt_reg, cnt_next;
    logic [2*DATA_W-1:0]   work_reg, work_next;
    logic [DATA_W-1:0]     op_reg, op_next;
    logic                  mode_reg, mode_next;
    logic                  sa_reg, sa_next;
    logic                  sb_reg, sb_next;
    logic [DATA_W-1:0]     res_hi_reg, res_hi_next;
    logic [DATA_W-1:0]     res_lo_reg, res_lo_next;
    logic [DATA_W-1:0]     hi_reg, hi_next;
    logic [DATA_W-1:0]     lo_reg, lo_next;
    logic [2*DATA_W-1:0]   step_work;
    logic [2*DATA_W-1:0]   neg_work;
    logic                  div0;

    assign div0 = (bus.MDCtrl == MD_DIV) && (bus.B == '0);

    md_iter_step u_step (
        .mode    (mode_reg),
        .work    (work_reg),
        .operand (op_reg),
        .result  (step_work)
    );

    assign neg_work = ~work_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            work_reg   <= '0;
            op_reg     <= '0;
            mode_reg   <= MD_MULT;
            sa_reg     <= 1'b0;
            sb_reg     <= 1'b0;
            res_hi_reg <= '0;
            res_lo_reg <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            work_reg   <= work_next;
            op_reg     <= op_next;
            mode_reg   <= mode_next;
            sa_reg     <= sa_next;
            sb_reg     <= sb_next;
            res_hi_reg <= res_hi_next;
            res_lo_reg <= res_lo_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        work_next   = work_reg;
        op_next     = op_reg;
        mode_next   = mode_reg;
        sa_next     = sa_reg;
        sb_next     = sb_reg;
        res_hi_next = res_hi_reg;
        res_lo_next = res_lo_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        case (state_reg)
            IDLE: begin
                if (bus.HILOWrite) begin
                    hi_next = res_hi_reg;
                    lo_next = res_lo_reg;
                end
                if (bus.start && !div0) begin
                    state_next = CALC;
                    cnt_next   = '0;
                    work_next  = {{DATA_W{1'b0}}, abs32(bus.A)};
                    op_next    = abs32(bus.B);
                    mode_next  = bus.MDCtrl;
                    sa_next    = bus.A[DATA_W-1];
                    sb_next    = bus.B[DATA_W-1];
                end
            end
            CALC: begin
                work_next = step_work;
                cnt_next  = cnt_reg + 6'd1;
                if (cnt_reg == 6'(ITER_COUNT - 1)) begin
                    state_next = FIX;
                end
`ifdef MULT_DIV_FAST_MULT_EN
                if (mode_reg == MD_MULT) begin
                    work_next  = {{DATA_W{1'b0}}, work_reg[DATA_W-1:0]}
                               * {{DATA_W{1'b0}}, op_reg};
                    state_next = FIX;
                end
`endif
            end
            FIX: begin
                state_next = DONE;
                if (mode_reg == MD_MULT) begin
                    {res_hi_next, res_lo_next} = (sa_reg ^ sb_reg) ? neg_work : work_reg;
                end else begin
                    // Quotient truncates toward zero; remainder follows the dividend.
                    res_lo_next = (sa_reg ^ sb_reg) ? neg_work[DATA_W-1:0]
                                                    : work_reg[DATA_W-1:0];
                    res_hi_next = sa_reg ? (~work_reg[2*DATA_W-1:DATA_W] + 1'b1)
                                         : work_reg[2*DATA_W-1:DATA_W];
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.Hi   = hi_reg;
    assign bus.Lo   = lo_reg;
    assign bus.busy = (state_reg != IDLE);
    assign bus.done = (state_reg == DONE);
    assign bus.div0 = div0;

endmodule
